// File: rtl/map_arb_pkg.sv
// rtl/map_arb_pkg.sv - shared constants, tag type and round-robin search for the map read arbiter
package map_arb_pkg;

  localparam int MAP_SIZE_DEF = 24;
  localparam int MAP_CELLS    = MAP_SIZE_DEF * MAP_SIZE_DEF;
  localparam int MAX_REQ      = 8;
  localparam int ARB_IDX_W    = $clog2(MAX_REQ);

  typedef struct packed {
    logic                 valid;
    logic [ARB_IDX_W-1:0] idx;
    logic                 oob;
  } arb_tag_t;

  // Returns {found, index}; offsets are scanned high to low so the lowest offset from ptr wins.
  function automatic logic [ARB_IDX_W:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [ARB_IDX_W-1:0] ptr,
                                                 input int n);
    logic [ARB_IDX_W:0] r;
    int k;
    r = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (i < n) begin
        k = int'(ptr) + i;
        if (k >= n) k = k - n;
        if (req[k]) r = {1'b1, k[ARB_IDX_W-1:0]};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker with a registered rotation pointer
module rr_arbiter
  import map_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                 pixel_clk_in,
  input  logic                 rst_in,
  input  logic [NUM_REQ-1:0]   req,
  output logic                 pick_valid,
  output logic [ARB_IDX_W-1:0] pick_idx
);

  logic [ARB_IDX_W-1:0] rr_ptr;
  logic [ARB_IDX_W:0]   pick;

  always_comb begin
    pick       = rr_pick(MAX_REQ'(req), rr_ptr, NUM_REQ);
    pick_valid = pick[ARB_IDX_W];
    pick_idx   = pick[ARB_IDX_W-1:0];
  end

  always_ff @(posedge pixel_clk_in) begin
    if (!rst_in) begin
      rr_ptr <= '0;
    end else if (pick_valid) begin
      rr_ptr <= (int'(pick_idx) + 1 == NUM_REQ) ? '0 : pick_idx + ARB_IDX_W'(1);
    end
  end

endmodule

// File: rtl/map_read_arbiter.sv
// rtl/map_read_arbiter.sv - round-robin sharing of the map BRAM read port with tagged data return
// Optional out-of-range substitution: MAP_READ_ARBITER_OOB_CHECK_EN
module map_read_arbiter
  import map_arb_pkg::*;
#(
  parameter int                NUM_REQ      = 2,
  parameter int                MAP_SIZE     = MAP_SIZE_DEF,
  parameter int                ADDR_W       = $clog2(MAP_SIZE * MAP_SIZE),
  parameter int                DATA_W       = 8,
  parameter int                READ_LATENCY = 2,
  parameter logic [DATA_W-1:0] OOB_DATA     = DATA_W'(1)
) (
  input  logic                      pixel_clk_in,
  input  logic                      rst_in,
  input  logic [NUM_REQ-1:0]        req_in,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_in,
  output logic [NUM_REQ-1:0]        gnt_out,
  output logic [DATA_W-1:0]         data_out,
  output logic [NUM_REQ-1:0]        data_valid_out,
  output logic [ADDR_W-1:0]         bram_addr_out,
  input  logic [DATA_W-1:0]         bram_data_in,
  output logic                      busy_out
);

  localparam logic [ADDR_W:0] CELLS_L = (ADDR_W + 1)'(MAP_SIZE * MAP_SIZE);

  logic                 pick_valid;
  logic [ARB_IDX_W-1:0] pick_idx;
  logic [ADDR_W-1:0]    pick_addr;
  arb_tag_t             new_tag;
  arb_tag_t             tags [READ_LATENCY+1];

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .pixel_clk_in (pixel_clk_in),
    .rst_in       (rst_in),
    .req          (req_in),
    .pick_valid   (pick_valid),
    .pick_idx     (pick_idx)
  );

  always_comb begin
    pick_addr     = addr_in[int'(pick_idx)*ADDR_W +: ADDR_W];
    new_tag.valid = pick_valid;
    new_tag.idx   = pick_idx;
`ifdef MAP_READ_ARBITER_OOB_CHECK_EN
    new_tag.oob   = pick_valid && ({1'b0, pick_addr} >= CELLS_L);
`else
    new_tag.oob   = 1'b0;
`endif
  end

  // tags[k] describes the read whose address went out k cycles ago; the last stage lines up with douta.
  always_ff @(posedge pixel_clk_in) begin
    if (!rst_in) begin
      gnt_out        <= '0;
      bram_addr_out  <= '0;
      data_out       <= '0;
      data_valid_out <= '0;
      for (int k = 0; k <= READ_LATENCY; k++) tags[k] <= '0;
    end else begin
      gnt_out <= pick_valid ? (NUM_REQ'(1) << pick_idx) : '0;
      if (pick_valid) bram_addr_out <= pick_addr;
      tags[0] <= new_tag;
      for (int k = 1; k <= READ_LATENCY; k++) tags[k] <= tags[k-1];
      data_valid_out <= tags[READ_LATENCY].valid ? (NUM_REQ'(1) << tags[READ_LATENCY].idx) : '0;
      if (tags[READ_LATENCY].valid) begin
`ifdef MAP_READ_ARBITER_OOB_CHECK_EN
        data_out <= tags[READ_LATENCY].oob ? OOB_DATA : bram_data_in;
`else
        data_out <= bram_data_in;
`endif
      end
    end
  end

  always_comb begin
    busy_out = |gnt_out;
    for (int k = 0; k <= READ_LATENCY; k++) busy_out = busy_out | tags[k].valid;
  end

endmodule

// File: tb/tb_map_read_arbiter.sv
// tb/tb_map_read_arbiter.sv - directed and randomized checks of map_read_arbiter against a queue-based model
module tb_map_read_arbiter;

  localparam int N     = 2;
  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int RL    = 2;
  localparam int CELLS = 24 * 24;

  logic            pixel_clk_in = 1'b0;
  logic            rst_in;
  logic [N-1:0]    req_in;
  logic [N*AW-1:0] addr_in;
  logic [N-1:0]    gnt_out;
  logic [DW-1:0]   data_out;
  logic [N-1:0]    data_valid_out;
  logic [AW-1:0]   bram_addr_out;
  logic [DW-1:0]   bram_data_in;
  logic            busy_out;

  always #5 pixel_clk_in = ~pixel_clk_in;

  map_read_arbiter #(.NUM_REQ(N), .MAP_SIZE(24), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)) dut (
    .pixel_clk_in   (pixel_clk_in),
    .rst_in         (rst_in),
    .req_in         (req_in),
    .addr_in        (addr_in),
    .gnt_out        (gnt_out),
    .data_out       (data_out),
    .data_valid_out (data_valid_out),
    .bram_addr_out  (bram_addr_out),
    .bram_data_in   (bram_data_in),
    .busy_out       (busy_out)
  );

  // Two-cycle BRAM: address seen at an edge, word visible two edges later.
  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] bram_d1;
  always @(posedge pixel_clk_in) begin
    bram_d1      <= mem[bram_addr_out];
    bram_data_in <= bram_d1;
  end

  typedef struct {
    int            due;
    int            idx;
    logic [DW-1:0] data;
  } ret_t;

  ret_t          q[$];
  int            vectors = 0;
  int            miscompares = 0;
  int            cyc = 0;
  int            model_ptr = 0;
  logic [N-1:0]  exp_gnt = '0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_data = '0;

  function automatic logic [DW-1:0] expect_word(input int a);
`ifdef MAP_READ_ARBITER_OOB_CHECK_EN
    if (a >= CELLS) return 8'd1;
`endif
    return mem[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // What the coming edge must do, from the current inputs.
  task automatic model_edge();
    int w;
    int a;
    if (!rst_in) begin
      q.delete();
      model_ptr = 0;
      exp_gnt   = '0;
      exp_addr  = '0;
      exp_data  = '0;
    end else begin
      w = -1;
      for (int off = 0; off < N; off++) begin
        int c;
        c = (model_ptr + off) % N;
        if (w < 0 && req_in[c]) w = c;
      end
      exp_gnt = '0;
      if (w >= 0) begin
        a = int'(addr_in[w*AW +: AW]);
        exp_gnt[w] = 1'b1;
        exp_addr   = AW'(a);
        q.push_back('{cyc + 1 + RL + 1, w, expect_word(a)});
        model_ptr = (w + 1) % N;
      end
    end
  endtask

  task automatic compare();
    logic [N-1:0] exp_dv;
    exp_dv = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_dv[q[0].idx] = 1'b1;
      exp_data = q[0].data;
      void'(q.pop_front());
    end
    check("gnt", gnt_out, exp_gnt);
    check("bram_addr", bram_addr_out, exp_addr);
    check("data_valid", data_valid_out, exp_dv);
    check("data", data_out, exp_data);
    check("busy", busy_out, q.size() != 0);
  endtask

  task automatic cycle();
    model_edge();
    @(posedge pixel_clk_in);
    @(negedge pixel_clk_in);
    cyc++;
    compare();
  endtask

  task automatic drain(input int n);
    req_in = '0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = DW'($urandom);
    rst_in  = 1'b0;
    req_in  = '0;
    addr_in = '0;

    // Reset state
    cycle();
    cycle();
    check("rst_gnt", gnt_out, 0);
    check("rst_dv", data_valid_out, 0);
    check("rst_data", data_out, 0);
    check("rst_addr", bram_addr_out, 0);
    check("rst_busy", busy_out, 0);
    rst_in = 1'b1;

    // Single read
    mem[49] = 8'd3;
    req_in = 2'b01;
    addr_in[0 +: AW] = 10'd49;
    cycle();
    check("single_gnt", gnt_out, 2'b01);
    check("single_addr", bram_addr_out, 49);
    req_in = '0;
    cycle();
    cycle();
    cycle();
    check("single_dv", data_valid_out, 2'b01);
    check("single_data", data_out, 3);

    // Contention from a fresh pointer
    rst_in = 1'b0;
    cycle();
    rst_in = 1'b1;
    mem[5] = 8'h55;
    mem[7] = 8'h77;
    addr_in[0 +: AW]  = 10'd5;
    addr_in[AW +: AW] = 10'd7;
    req_in = 2'b11;
    cycle(); check("cont_gnt1", gnt_out, 2'b01);
    cycle(); check("cont_gnt2", gnt_out, 2'b10);
    cycle(); check("cont_gnt3", gnt_out, 2'b01);
    cycle(); check("cont_gnt4", gnt_out, 2'b10);
    check("cont_dv1", data_valid_out, 2'b01);
    check("cont_data1", data_out, 8'h55);
    req_in = '0;
    cycle();
    check("cont_dv2", data_valid_out, 2'b10);
    check("cont_data2", data_out, 8'h77);
    drain(3);

    // Priority rotation with the pointer at 1
    req_in = 2'b01;
    cycle();
    req_in = 2'b11;
    cycle(); check("rot_first", gnt_out, 2'b10);
    cycle(); check("rot_second", gnt_out, 2'b01);
    drain(4);

    // Back-to-back grants to one requester
    mem[100] = 8'hA1;
    mem[101] = 8'hB2;
    req_in = 2'b01;
    addr_in[0 +: AW] = 10'd100;
    cycle();
    addr_in[0 +: AW] = 10'd101;
    cycle(); check("b2b_gnt2", gnt_out, 2'b01);
    req_in = '0;
    cycle();
    cycle(); check("b2b_dv1", data_valid_out, 2'b01); check("b2b_data1", data_out, 8'hA1);
    cycle(); check("b2b_dv2", data_valid_out, 2'b01); check("b2b_data2", data_out, 8'hB2);
    drain(2);

    // Out-of-range address
    mem[600] = 8'h9C;
    req_in = 2'b01;
    addr_in[0 +: AW] = 10'd600;
    cycle();
    req_in = '0;
    cycle();
    cycle();
    cycle();
    check("oob_dv", data_valid_out, 2'b01);
`ifdef MAP_READ_ARBITER_OOB_CHECK_EN
    check("oob_data", data_out, 8'd1);
`else
    check("oob_data", data_out, 8'h9C);
`endif
    drain(2);

    // Reset while a read is in flight
    mem[25] = 8'h42;
    req_in = 2'b01;
    addr_in[0 +: AW] = 10'd25;
    cycle();
    rst_in = 1'b0;
    req_in = '0;
    cycle();
    check("rstmid_gnt", gnt_out, 0);
    check("rstmid_data", data_out, 0);
    check("rstmid_addr", bram_addr_out, 0);
    check("rstmid_busy", busy_out, 0);
    rst_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("rstmid_no_dv", data_valid_out, 0);
    end
    req_in = 2'b11;
    cycle(); check("rstmid_ptr", gnt_out, 2'b01);
    drain(4);

    // Randomized traffic with occasional reset
    for (int t = 0; t < 3000; t++) begin
      rst_in = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < N; i++) begin
        if (req_in[i]) begin
          if (gnt_out[i]) begin
            if ($urandom_range(0, 2) == 0) addr_in[i*AW +: AW] = AW'($urandom_range(0, 1023));
            else req_in[i] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          req_in[i] = 1'b1;
          addr_in[i*AW +: AW] = AW'($urandom_range(0, 1023));
        end
      end
      cycle();
    end
    rst_in = 1'b1;
    drain(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
